fp_operand_unpack: RTL and testbench

Parametrised, pipelined operand front end for the variable-precision floating-point multiplier. It accepts an operand pair over a valid/ready handshake and splits each operand into sign, biased exponent and hidden-bit-extended mantissa. It also classifies each operand (zero/subnormal/normal/inf/NaN) and truncates low mantissa bits according to a run-time precision select. It sits between the operand source and the mantissa multiplier/exponent adder, and supports BFloat16 (default), FP16 and FP32 by parameter.

---
 rtl/fp_operand_unpack.sv | 173 +++++++++++++++++
 tb/tb_fp_operand_unpack.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_operand_unpack.sv
// Two-stage operand front end for the FP multiplier. It registers an operand pair,
// then decodes sign, exponent, hidden-bit mantissa and class, with run-time fraction truncation.
module fp_operand_unpack #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 7,
    parameter int PREC_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] A,
    input  logic [EXP_W+MAN_W:0] B,
    input  logic [PREC_W-1:0]    prec,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 Sa,
    output logic                 Sb,
    output logic                 s_prod,
    output logic [EXP_W-1:0]     expa,
    output logic [EXP_W-1:0]     expb,
    output logic [MAN_W:0]       manta,
    output logic [MAN_W:0]       mantb,
    output logic [2:0]           cls_a,
    output logic [2:0]           cls_b,
    output logic                 special
);
    localparam int OP_W = 1 + EXP_W + MAN_W;

    localparam logic [2:0] CLS_NORMAL = 3'b000;
    localparam logic [2:0] CLS_ZERO   = 3'b001;
    localparam logic [2:0] CLS_SUB    = 3'b010;
    localparam logic [2:0] CLS_INF    = 3'b011;
    localparam logic [2:0] CLS_NAN    = 3'b100;

    logic                  s1_en;
    logic                  s2_en;
    logic                  s1_valid_q;
    logic                  s1_valid_d;
    logic [1:0][OP_W-1:0]  op_q;
    logic [1:0][OP_W-1:0]  op_d;
    logic [PREC_W-1:0]     prec_q;
    logic [PREC_W-1:0]     prec_d;
    logic                  out_valid_q;

    // Each stage may advance whenever the stage after it is empty or draining.
    assign s2_en    = !out_valid_q || out_ready;
    assign s1_en    = !s1_valid_q || s2_en;
    assign in_ready = s1_en;

    always_comb begin
        s1_valid_d = s1_valid_q;
        op_d       = op_q;
        prec_d     = prec_q;
        if (s1_en) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                op_d[0] = A;
                op_d[1] = B;
                prec_d  = prec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            op_q       <= '0;
            prec_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            op_q       <= op_d;
            prec_q     <= prec_d;
        end
    end

    logic [1:0]              sign_d;
    logic [1:0]              spec_d;
    logic [1:0][EXP_W-1:0]   exp_d;
    logic [1:0][MAN_W:0]     mant_d;
    logic [1:0][2:0]         cls_d;
    logic [31:0]             prec_ext;

    assign prec_ext = 32'(prec_q);

    for (genvar gi = 0; gi < 2; gi++) begin : g_op
        logic [EXP_W-1:0] exp_f;
        logic [MAN_W-1:0] frac_f;
        logic [MAN_W-1:0] frac_m;
        logic             exp_zero;
        logic             exp_ones;
        logic             frac_nz;

        assign sign_d[gi] = op_q[gi][OP_W-1];
        assign exp_f      = op_q[gi][OP_W-2 -: EXP_W];
        assign frac_f     = op_q[gi][MAN_W-1:0];
        assign exp_zero   = (exp_f == '0);
        assign exp_ones   = &exp_f;
        assign frac_nz    = |frac_f;

        // Bit j survives only when it lies at or above the drop count; a drop
        // count beyond MAN_W therefore clears the whole fraction.
        for (genvar gj = 0; gj < MAN_W; gj++) begin : g_mask
            localparam logic [31:0] BIT_IDX = 32'(gj);
            assign frac_m[gj] = (prec_ext > BIT_IDX) ? 1'b0 : frac_f[gj];
        end

        // Class is taken from the unmasked fraction so truncation cannot turn NaN into inf.
        assign cls_d[gi] = exp_zero ? (frac_nz ? CLS_SUB : CLS_ZERO)
                         : exp_ones ? (frac_nz ? CLS_NAN : CLS_INF)
                         : CLS_NORMAL;

        assign exp_d[gi]  = exp_f;
        assign mant_d[gi] = {!exp_zero, frac_m};
        assign spec_d[gi] = (cls_d[gi] == CLS_ZERO) || (cls_d[gi] == CLS_INF)
                         || (cls_d[gi] == CLS_NAN);
    end

    logic              sa_q;
    logic              sb_q;
    logic              s_prod_q;
    logic [EXP_W-1:0]  expa_q;
    logic [EXP_W-1:0]  expb_q;
    logic [MAN_W:0]    manta_q;
    logic [MAN_W:0]    mantb_q;
    logic [2:0]        cls_a_q;
    logic [2:0]        cls_b_q;
    logic              special_q;

    // Data registers only load on a real transfer; a bubble just clears valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            s_prod_q    <= 1'b0;
            expa_q      <= '0;
            expb_q      <= '0;
            manta_q     <= '0;
            mantb_q     <= '0;
            cls_a_q     <= '0;
            cls_b_q     <= '0;
            special_q   <= 1'b0;
        end else if (s2_en) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                sa_q      <= sign_d[0];
                sb_q      <= sign_d[1];
                s_prod_q  <= sign_d[0] ^ sign_d[1];
                expa_q    <= exp_d[0];
                expb_q    <= exp_d[1];
                manta_q   <= mant_d[0];
                mantb_q   <= mant_d[1];
                cls_a_q   <= cls_d[0];
                cls_b_q   <= cls_d[1];
                special_q <= spec_d[0] | spec_d[1];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign Sa        = sa_q;
    assign Sb        = sb_q;
    assign s_prod    = s_prod_q;
    assign expa      = expa_q;
    assign expb      = expb_q;
    assign manta     = manta_q;
    assign mantb     = mantb_q;
    assign cls_a     = cls_a_q;
    assign cls_b     = cls_b_q;
    assign special   = special_q;

endmodule

// File: tb/tb_fp_operand_unpack.sv
// Directed bench for fp_operand_unpack: BFloat16 and FP16 decode vectors,
// backpressure, continuous streaming and mid-traffic reset.
module tb_fp_operand_unpack;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] A;
    logic [15:0] B;
    logic [2:0]  prec;
    logic        Sa, Sb, s_prod, special;
    logic [7:0]  expa, expb, manta, mantb;
    logic [2:0]  cls_a, cls_b;

    logic [15:0] h_a, h_b;
    logic [3:0]  h_prec;
    logic        h_in_ready, h_out_valid;
    logic        h_sa, h_sb, h_sprod, h_special;
    logic [4:0]  h_expa, h_expb;
    logic [10:0] h_manta, h_mantb;
    logic [2:0]  h_cls_a, h_cls_b;

    fp_operand_unpack dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .prec(prec), .out_valid(out_valid), .out_ready(out_ready),
        .Sa(Sa), .Sb(Sb), .s_prod(s_prod), .expa(expa), .expb(expb),
        .manta(manta), .mantb(mantb), .cls_a(cls_a), .cls_b(cls_b), .special(special)
    );

    fp_operand_unpack #(.EXP_W(5), .MAN_W(10), .PREC_W(4)) dut_h (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(h_in_ready),
        .A(h_a), .B(h_b), .prec(h_prec), .out_valid(h_out_valid), .out_ready(out_ready),
        .Sa(h_sa), .Sb(h_sb), .s_prod(h_sprod), .expa(h_expa), .expb(h_expb),
        .manta(h_manta), .mantb(h_mantb), .cls_a(h_cls_a), .cls_b(h_cls_b), .special(h_special)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] va [16];
    logic [15:0] vb [16];
    logic [2:0]  vp [16];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    function automatic logic [41:0] pack_out();
        return {Sa, Sb, s_prod, expa, expb, manta, mantb, cls_a, cls_b, special};
    endfunction

    // Reference decode for one BFloat16 operand.
    function automatic void ref_op(input logic [15:0] x, input int p,
                                   output logic [2:0] c, output logic [7:0] m);
        logic [7:0] e;
        logic [6:0] f;
        logic [6:0] keep;
        int         k;
        e = x[14:7];
        f = x[6:0];
        if (e == 8'h00)      c = (f == 0) ? 3'd1 : 3'd2;
        else if (e == 8'hFF) c = (f == 0) ? 3'd3 : 3'd4;
        else                 c = 3'd0;
        k    = (p > 7) ? 7 : p;
        keep = 7'h7F << k;
        m    = {(e != 8'h00), f & keep};
    endfunction

    function automatic logic [41:0] ref_decode(input logic [15:0] a, input logic [15:0] b,
                                               input logic [2:0] p);
        logic [2:0] ca, cb;
        logic [7:0] ma, mb;
        logic       sp;
        ref_op(a, int'(p), ca, ma);
        ref_op(b, int'(p), cb, mb);
        sp = (ca == 3'd1) || (ca == 3'd3) || (ca == 3'd4) ||
             (cb == 3'd1) || (cb == 3'd3) || (cb == 3'd4);
        return {a[15], b[15], a[15] ^ b[15], a[14:7], b[14:7], ma, mb, ca, cb, sp};
    endfunction

    // One pair through an idle pipe; returns at the negedge where it should be visible.
    task automatic send_one(input logic [15:0] a, input logic [15:0] b, input logic [2:0] p);
        @(negedge clk);
        A = a; B = b; prec = p; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("out_valid_lat2", out_valid, 1'b1);
    endtask

    task automatic send_h(input logic [15:0] a, input logic [15:0] b, input logic [3:0] p);
        @(negedge clk);
        h_a = a; h_b = b; h_prec = p; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("h_out_valid_lat2", h_out_valid, 1'b1);
    endtask

    task automatic run_stream(input string name, input int n, input int stall, input bit cont);
        logic [41:0] q[$];
        int sent;
        int got;
        int cyc;
        sent = 0;
        got  = 0;
        cyc  = 0;
        while ((sent < n || q.size() > 0) && cyc < 200) begin
            @(negedge clk);
            out_ready = (cyc >= stall);
            in_valid  = (sent < n);
            if (sent < n) begin
                A = va[sent]; B = vb[sent]; prec = vp[sent];
            end
            #1;
            check_eq($sformatf("%s_in_ready_c%0d", name, cyc), in_ready,
                     !(q.size() == 2 && !out_ready));
            if (cont && cyc >= 2 && cyc < n + 2)
                check_eq($sformatf("%s_out_valid_c%0d", name, cyc), out_valid, 1'b1);
            if (out_valid) begin
                if (q.size() == 0) begin
                    check_eq($sformatf("%s_spurious_c%0d", name, cyc), out_valid, 1'b0);
                end else begin
                    check_eq($sformatf("%s_pair%0d_c%0d", name, got, cyc), pack_out(), q[0]);
                    if (out_ready) begin
                        void'(q.pop_front());
                        got++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_decode(va[sent], vb[sent], vp[sent]));
                sent++;
            end
            cyc++;
        end
        check_eq($sformatf("%s_delivered", name), got, n);
        check_eq($sformatf("%s_in_time", name), (cyc < 200), 1'b1);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; prec = '0; h_a = '0; h_b = '0; h_prec = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_outputs", pack_out(), 42'd0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        rst = 1'b0;

        send_one(16'h3F80, 16'hC040, 3'd0);
        check_eq("t1_Sa", Sa, 1'b0);
        check_eq("t1_expa", expa, 8'h7F);
        check_eq("t1_manta", manta, 8'h80);
        check_eq("t1_Sb", Sb, 1'b1);
        check_eq("t1_expb", expb, 8'h80);
        check_eq("t1_mantb", mantb, 8'hC0);
        check_eq("t1_s_prod", s_prod, 1'b1);
        check_eq("t1_cls", {cls_a, cls_b}, 6'b000_000);
        check_eq("t1_special", special, 1'b0);

        send_one(16'h0000, 16'h7FC1, 3'd7);
        check_eq("t2_cls_a", cls_a, 3'b001);
        check_eq("t2_manta", manta, 8'h00);
        check_eq("t2_cls_b", cls_b, 3'b100);
        check_eq("t2_mantb", mantb, 8'h80);
        check_eq("t2_expb", expb, 8'hFF);
        check_eq("t2_special", special, 1'b1);

        send_one(16'h3FFF, 16'h3F80, 3'd3);
        check_eq("t3_manta_p3", manta, 8'hF8);
        send_one(16'h3FFF, 16'h3F80, 3'd7);
        check_eq("t3_manta_p7", manta, 8'h80);
        send_one(16'h0001, 16'h3F80, 3'd7);
        check_eq("t3_sub_cls", cls_a, 3'b010);
        check_eq("t3_sub_manta", manta, 8'h00);
        check_eq("t3_sub_special", special, 1'b0);
        send_one(16'h0001, 16'h7F80, 3'd0);
        check_eq("t3_sub_manta_p0", manta, 8'h01);
        check_eq("t3_inf_cls_b", cls_b, 3'b011);
        check_eq("t3_inf_special", special, 1'b1);

        va[0] = 16'h3F80; vb[0] = 16'h4000; vp[0] = 3'd0;
        va[1] = 16'hBFC0; vb[1] = 16'h0000; vp[1] = 3'd2;
        va[2] = 16'h7F80; vb[2] = 16'h0005; vp[2] = 3'd1;
        va[3] = 16'h7FFF; vb[3] = 16'hC2F7; vp[3] = 3'd7;
        run_stream("bp", 4, 5, 1'b0);

        for (int i = 0; i < 16; i++) begin
            va[i] = 16'(i * 16'h1357) ^ 16'h3C5A;
            vb[i] = 16'(i * 16'h2B1D) ^ 16'hC0A5;
            vp[i] = 3'(i % 8);
        end
        va[3] = 16'h7F80; vb[5] = 16'h0000; va[9] = 16'hFFC0;
        run_stream("cont", 16, 0, 1'b1);

        @(negedge clk);
        A = 16'h4040; B = 16'h4080; prec = 3'd0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        A = 16'hC100; B = 16'h3F80;
        @(negedge clk);
        check_eq("rs_inflight_valid", out_valid, 1'b1);
        rst = 1'b1; A = 16'h4110; B = 16'h4120;
        @(negedge clk);
        check_eq("rs_out_valid", out_valid, 1'b0);
        check_eq("rs_outputs", pack_out(), 42'd0);
        check_eq("rs_in_ready", in_ready, 1'b1);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_eq("rs_no_ghost1", out_valid, 1'b0);
        @(negedge clk);
        check_eq("rs_no_ghost2", out_valid, 1'b0);
        send_one(16'h4040, 16'hBF80, 3'd1);
        check_eq("rs_after_pair", pack_out(), ref_decode(16'h4040, 16'hBF80, 3'd1));
        check_eq("rs_after_expa", expa, 8'h80);
        check_eq("rs_after_manta", manta, 8'hC0);

        send_h(16'h7C00, 16'h3C00, 4'd0);
        check_eq("h_inf_cls", h_cls_a, 3'b011);
        check_eq("h_inf_manta", h_manta, 11'h400);
        check_eq("h_inf_expa", h_expa, 5'h1F);
        check_eq("h_inf_special", h_special, 1'b1);
        send_h(16'h3C00, 16'hBC00, 4'd0);
        check_eq("h_one_expa", h_expa, 5'h0F);
        check_eq("h_one_manta", h_manta, 11'h400);
        check_eq("h_one_sprod", h_sprod, 1'b1);
        check_eq("h_one_special", h_special, 1'b0);
        send_h(16'h3FFF, 16'h3FFF, 4'd3);
        check_eq("h_mask_p3", h_manta, 11'h7F8);
        send_h(16'h3FFF, 16'h3FFF, 4'd10);
        check_eq("h_mask_p10", h_manta, 11'h400);
        send_h(16'h3FFF, 16'h7E01, 4'd12);
        check_eq("h_mask_p12", h_manta, 11'h400);
        check_eq("h_nan_kept", h_cls_b, 3'b100);
        check_eq("h_nan_mantb", h_mantb, 11'h400);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
